// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, fetch-unit state encoding and the
// packed instruction word type.
// Ports: none (package).
package cpu_pkg;

  localparam int CPU_DATA_W     = 8;
  localparam int CPU_ADDR_W     = 16;
  localparam int CPU_INSN_BYTES = 3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ifu_state_t;

  // Lowest-address byte sits in bits [CPU_DATA_W-1:0].
  typedef logic [CPU_DATA_W*CPU_INSN_BYTES-1:0] insn_t;

endpackage

// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bundle: byte read port to program memory, branch redirect input
// and the valid/ready instruction port towards execution control.
// Ports: master = fetch unit side, slave = memory / consumer / branch side.
interface ifu_prefetch_if #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int INSN_BYTES = 3
);

  logic                         mem_re;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         mem_ready;
  logic                         br_valid;
  logic [ADDR_W-1:0]            br_target;
  logic                         instr_valid;
  logic [DATA_W*INSN_BYTES-1:0] instr_data;
  logic [ADDR_W-1:0]            instr_pc;
  logic                         instr_ready;
  logic [ADDR_W-1:0]            fetch_pc;

  modport master (
    output mem_re, mem_addr, instr_valid, instr_data, instr_pc, fetch_pc,
    input  mem_rdata, mem_ready, br_valid, br_target, instr_ready
  );

  modport slave (
    input  mem_re, mem_addr, instr_valid, instr_data, instr_pc, fetch_pc,
    output mem_rdata, mem_ready, br_valid, br_target, instr_ready
  );

endinterface

// File: rtl/ifu_queue.sv
// Synchronous FIFO of DEPTH entries, W bits wide; flush beats push and pop.
// Latency: a push is visible at the head on the edge after it is written.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk/rst, push/push_dat, pop, flush, head_dat, count, full, empty.
module ifu_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign head_dat = store_q[rd_ptr_q];
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;

  // Storage needs no reset: the head is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: byte reads from program memory assembled into
// INSN_BYTES-wide words, queued DEPTH deep with their PC; branches flush.
// Latency: head valid on the edge after the last byte of a word is accepted.
// Backpressure: reads stall when the queue is full or mem_ready is low; a
// partially assembled word is held until space frees up.
// Ports: clk, rst (async, active high), bus (ifu_prefetch_if.master).
module ifu_prefetch
  import cpu_pkg::*;
#(
  parameter int                DATA_W     = CPU_DATA_W,
  parameter int                ADDR_W     = CPU_ADDR_W,
  parameter int                INSN_BYTES = CPU_INSN_BYTES,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input logic                clk,
  input logic                rst,
  ifu_prefetch_if.master     bus
);

  localparam int INSN_W = DATA_W * INSN_BYTES;
  localparam int IDX_W  = (INSN_BYTES > 1) ? $clog2(INSN_BYTES) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INSN_BYTES - 1);

  ifu_state_t                           state_q;
  logic [ADDR_W-1:0]                    fetch_pc_q;
  logic [ADDR_W-1:0]                    start_pc_q;
  logic [IDX_W-1:0]                     idx_q;
  logic [INSN_BYTES-1:0][DATA_W-1:0]    asm_q;
  logic [INSN_BYTES-1:0][DATA_W-1:0]    asm_next;

  logic                     accept;
  logic                     last_byte;
  logic                     q_push;
  logic                     q_pop;
  logic                     q_full;
  logic                     q_empty;
  logic [CNT_W-1:0]         q_count;
  logic [INSN_W+ADDR_W-1:0] q_head;

  // Gated by rst so no request is visible while reset is held.
  assign bus.mem_re   = !rst && (state_q == RUN) && (q_count < CNT_W'(DEPTH));
  assign bus.mem_addr = fetch_pc_q;
  assign bus.fetch_pc = fetch_pc_q;

  assign accept    = bus.mem_re && bus.mem_ready;
  assign last_byte = (idx_q == LAST_IDX);
  assign q_push    = accept && last_byte && !bus.br_valid;
  assign q_pop     = bus.instr_ready && !q_empty;

  // Current assembly with the incoming byte merged in, so the push carries
  // the final byte without waiting an extra cycle.
  always_comb begin
    asm_next        = asm_q;
    asm_next[idx_q] = bus.mem_rdata;
  end

  assign bus.instr_valid = !q_empty;
  assign bus.instr_data  = q_empty ? '0 : q_head[INSN_W+ADDR_W-1:ADDR_W];
  assign bus.instr_pc    = q_empty ? '0 : q_head[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      start_pc_q <= RESET_PC;
      idx_q      <= '0;
      asm_q      <= '0;
    end else if (bus.br_valid) begin
      // Any byte accepted this cycle belongs to the old stream; drop it.
      state_q    <= FLUSH;
      fetch_pc_q <= bus.br_target;
      start_pc_q <= bus.br_target;
      idx_q      <= '0;
    end else begin
      state_q <= RUN;
      if (accept) begin
        asm_q      <= asm_next;
        fetch_pc_q <= fetch_pc_q + 1'b1;
        if (last_byte) begin
          idx_q      <= '0;
          start_pc_q <= fetch_pc_q + 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  ifu_queue #(
    .W     (INSN_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .push_dat ({asm_next, start_pc_q}),
    .pop      (q_pop),
    .flush    (bus.br_valid),
    .head_dat (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Requests are only issued below DEPTH, so a push never meets a full queue.
  logic unused_full;
  assign unused_full = q_full;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a combinational byte memory model.
module tb_ifu_prefetch;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fails;

  ifu_prefetch_if bus ();

  ifu_prefetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: 0x11,0x22,...,0x66 at 0..5, varied by the high byte.
  function automatic logic [7:0] memb(input logic [15:0] a);
    logic [7:0] t;
    t = a[7:0] * 8'h11 + 8'h11;
    return t ^ a[15:8];
  endfunction

  function automatic insn_t insn_at(input logic [15:0] a);
    return {memb(a + 16'd2), memb(a + 16'd1), memb(a)};
  endfunction

  assign bus.mem_rdata = memb(bus.mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_pc;
  logic [15:0] exp_fetch;

  initial begin
    n_asserts = 0;
    n_fails   = 0;
    rst             = 1'b1;
    bus.mem_ready   = 1'b1;
    bus.instr_ready = 1'b0;
    bus.br_valid    = 1'b0;
    bus.br_target   = '0;
    step();
    step();

    // Reset state
    chk("rst_mem_re",   32'(bus.mem_re), 32'h0);
    chk("rst_valid",    32'(bus.instr_valid), 32'h0);
    chk("rst_data",     32'(bus.instr_data), 32'h0);
    chk("rst_pc",       32'(bus.instr_pc), 32'h0);
    chk("rst_fetch_pc", 32'(bus.fetch_pc), 32'h0);

    // First fetch and latency
    rst = 1'b0;
    #1;
    chk("first_re",   32'(bus.mem_re), 32'h1);
    chk("first_addr", 32'(bus.mem_addr), 32'h0);
    step();
    step();
    chk("pre_valid", 32'(bus.instr_valid), 32'h0);
    step();
    chk("c4_valid", 32'(bus.instr_valid), 32'h1);
    chk("c4_data",  32'(bus.instr_data), 32'h332211);
    chk("c4_pc",    32'(bus.instr_pc), 32'h0000);

    // Fill to DEPTH with no consumer
    repeat (9) step();
    chk("full_re",       32'(bus.mem_re), 32'h0);
    chk("full_fetch_pc", 32'(bus.fetch_pc), 32'h000C);
    step();
    step();
    chk("full_hold_re", 32'(bus.mem_re), 32'h0);
    chk("full_head_pc", 32'(bus.instr_pc), 32'h0000);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    #1;
    chk("pop_pc",   32'(bus.instr_pc), 32'h0003);
    chk("pop_data", 32'(bus.instr_data), 32'h665544);
    chk("resume_re",   32'(bus.mem_re), 32'h1);
    chk("resume_addr", 32'(bus.mem_addr), 32'h000C);

    // mem_ready toggling 1010... with a draining consumer
    exp_pc    = 16'h0003;
    exp_fetch = 16'h000C;
    for (int i = 0; i < 24; i++) begin
      bus.mem_ready   = (i % 2 == 0);
      bus.instr_ready = 1'b1;
      #1;
      if (bus.mem_re) begin
        chk("tog_addr", 32'(bus.mem_addr), 32'(exp_fetch));
        if (bus.mem_ready) exp_fetch = exp_fetch + 16'd1;
      end
      if (bus.instr_valid) begin
        chk("tog_pc",   32'(bus.instr_pc), 32'(exp_pc));
        chk("tog_data", 32'(bus.instr_data), 32'(insn_at(exp_pc)));
        exp_pc = exp_pc + 16'd3;
      end
      step();
    end
    chk("tog_progress", 32'(exp_pc >= 16'h000F), 32'h1);
    bus.instr_ready = 1'b0;
    bus.mem_ready   = 1'b1;

    // Branch during the second byte of the word at 0x0006
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (7) step();
    chk("br_pre_addr",  32'(bus.mem_addr), 32'h0007);
    chk("br_pre_valid", 32'(bus.instr_valid), 32'h1);
    bus.br_valid  = 1'b1;
    bus.br_target = 16'h0100;
    step();
    bus.br_valid = 1'b0;
    #1;
    chk("br_flush_valid", 32'(bus.instr_valid), 32'h0);
    chk("br_flush_re",    32'(bus.mem_re), 32'h0);
    step();
    chk("br_re",   32'(bus.mem_re), 32'h1);
    chk("br_addr", 32'(bus.mem_addr), 32'h0100);
    repeat (3) step();
    chk("br_valid1", 32'(bus.instr_valid), 32'h1);
    chk("br_pc",     32'(bus.instr_pc), 32'h0100);
    chk("br_data",   32'(bus.instr_data), 32'h322310);

    // Address wrap
    bus.br_valid  = 1'b1;
    bus.br_target = 16'hFFFE;
    step();
    bus.br_valid = 1'b0;
    #1;
    chk("wrap_flush_re", 32'(bus.mem_re), 32'h0);
    chk("wrap_flush_vl", 32'(bus.instr_valid), 32'h0);
    step();
    chk("wrap_a0", 32'(bus.mem_addr), 32'hFFFE);
    step();
    chk("wrap_a1", 32'(bus.mem_addr), 32'hFFFF);
    step();
    chk("wrap_a2", 32'(bus.mem_addr), 32'h0000);
    step();
    chk("wrap_pc",   32'(bus.instr_pc), 32'hFFFE);
    chk("wrap_data", 32'(bus.instr_data), 32'h11FF10);
    repeat (3) step();
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    #1;
    chk("wrap_next_pc",   32'(bus.instr_pc), 32'h0001);
    chk("wrap_next_data", 32'(bus.instr_data), 32'h443322);

    // Redirect while already flushing
    bus.br_valid  = 1'b1;
    bus.br_target = 16'h0200;
    step();
    bus.br_target = 16'h0040;
    step();
    bus.br_valid = 1'b0;
    #1;
    chk("rebr_re",    32'(bus.mem_re), 32'h0);
    chk("rebr_fetch", 32'(bus.fetch_pc), 32'h0040);
    chk("rebr_valid", 32'(bus.instr_valid), 32'h0);
    step();
    chk("rebr_addr", 32'(bus.mem_addr), 32'h0040);

    // Reset mid-assembly with two words queued
    repeat (7) step();
    chk("mid_valid", 32'(bus.instr_valid), 32'h1);
    chk("mid_pc",    32'(bus.instr_pc), 32'h0040);
    chk("mid_data",  32'(bus.instr_data), 32'h736251);
    chk("mid_addr",  32'(bus.mem_addr), 32'h0047);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.instr_valid), 32'h0);
    chk("arst_re",    32'(bus.mem_re), 32'h0);
    chk("arst_fetch", 32'(bus.fetch_pc), 32'h0000);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_re",   32'(bus.mem_re), 32'h1);
    chk("post_rst_addr", 32'(bus.mem_addr), 32'h0000);
    repeat (3) step();
    chk("post_rst_pc",   32'(bus.instr_pc), 32'h0000);
    chk("post_rst_data", 32'(bus.instr_data), 32'h332211);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised instruction fetch unit with a prefetch queue; successor to the fixed 3-byte raw-instruction fetch path.
- Issues one-byte-at-a-time reads to program memory over a ready-handshaked port.
- Assembles INSN_BYTES bytes into one instruction word and buffers up to DEPTH instructions, each tagged with its PC.
- The execution control unit consumes instructions via valid/ready; branches flush the queue and redirect fetch.

Parameters:
- DATA_W, 8: memory byte width.
- ADDR_W, 16: fetch address width.
- INSN_BYTES, 3: bytes per instruction; must be >= 1.
- DEPTH, 4: instruction queue entries; power of two, >= 2.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_re  out  1  byte read request.
- mem_addr  out  ADDR_W  request address.
- mem_rdata  in  DATA_W  read data; valid when mem_re && mem_ready.
- mem_ready  in  1  memory accepts the request and returns data in the same cycle.
- br_valid  in  1  redirect request, one-cycle pulse.
- br_target  in  ADDR_W  redirect address.
- instr_valid  out  1  queue head valid.
- instr_data  out  DATA_W*INSN_BYTES  head instruction; lowest-address byte in bits [DATA_W-1:0].
- instr_pc  out  ADDR_W  address of the head's first byte.
- instr_ready  in  1  consumer pops the head when instr_valid is also high.
- fetch_pc  out  ADDR_W  next byte address to request.

Behaviour:
- Reset (async, any cycle, including mid-assembly):
  - fetch_pc=RESET_PC, byte index=0, queue count=0.
  - mem_re=0, instr_valid=0, instr_data=0, instr_pc=0.
- States:
  - RUN: mem_re = (count < DEPTH). mem_addr = fetch_pc.
  - FLUSH: one cycle; mem_re=0. Returns to RUN.
- Handshake: a byte is accepted when mem_re && mem_ready. On acceptance:
  - store the byte at the current index in the assembly register;
  - fetch_pc += 1, wrapping modulo 2^ADDR_W (0xFFFF -> 0x0000 at default);
  - index += 1.
- Push: when the accepted byte is at index INSN_BYTES-1:
  - write {assembly, start_pc} into the queue at the next edge;
  - index=0; start_pc=new fetch_pc.
  - Space is guaranteed: the request was issued only with count < DEPTH.
- Latency:
  - First request is issued in the first cycle after rst deasserts.
  - With mem_ready=1 continuously, instr_valid rises on the edge after the INSN_BYTES-th accept (cycle INSN_BYTES+1).
  - No bypass from memory to instr_data.
- Outputs: instr_valid, instr_data and instr_pc are driven from the queue head. Head data is stable while instr_valid && !instr_ready.
- Pop and push in the same cycle: count is unchanged; pointers both advance.
- Full (count==DEPTH): mem_re=0. A partial assembly is held intact and resumes after a pop.
- Empty: instr_valid=0; instr_ready is ignored.
- br_valid (highest priority, any state):
  - at the next edge: count=0, pointers reset, index=0, fetch_pc=start_pc=br_target, state=FLUSH;
  - a byte accepted in the same cycle is discarded;
  - a pop in the same cycle has no additional effect;
  - instr_valid=0 from the next cycle.
- br_valid during FLUSH: restarts FLUSH with the new target.
- mem_ready low: mem_re and mem_addr are held stable until accepted. No request is ever dropped except by br_valid.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W/ADDR_W/INSN_BYTES defaults;
  - ifu_state_t enum {RUN, FLUSH};
  - insn_t typedef (packed DATA_W*INSN_BYTES).
- Sub-module ifu_queue: synchronous FIFO (DEPTH x (insn + ADDR_W)) with push/pop/flush, count, full, empty. Flush takes priority over push and pop.

Test Plan:
- Reset then mem_ready=1, memory[0..5]=11,22,33,44,55,66 -> cycle 4: instr_valid=1, instr_data=0x332211, instr_pc=0x0000. Next: 0x665544 @0x0003.
- instr_ready=0 with mem_ready=1 -> after 4 instructions, mem_re=0 and count=4. Pulse instr_ready one cycle -> fetch resumes at 0x000C and the head advances to pc 0x0003.
- Toggle mem_ready 1010... -> mem_addr is held while ready is low, no byte is skipped, and instructions match memory contents.
- Midway through the second byte of an instruction at 0x0006, br_valid=1 with br_target=0x0100 -> the next-cycle queue is empty, mem_re=0 (FLUSH), the following request is at 0x0100, and the first instruction has pc 0x0100.
- br_target=0xFFFE -> bytes are fetched at 0xFFFE, 0xFFFF, 0x0000; instr_pc=0xFFFE; the next instr_pc is 0x0001.
- Assert rst for one cycle mid-assembly with 2 queued -> instr_valid=0 immediately, and the next request is at RESET_PC.
